// File: rtl/pipe_trace_monitor.sv
// Saturating core event counters plus a show-ahead retirement trace FIFO,
// drained through a valid/ready port that keeps working while enable is low.
module pipe_trace_monitor #(
  parameter int XLEN        = 64,
  parameter int CNT_W       = 32,
  parameter int TRACE_DEPTH = 16,
  parameter int TRACE_MODE  = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           clear,
  input  logic                           stall_if,
  input  logic                           stall_id,
  input  logic                           flush_ex,
  input  logic                           branch_taken,
  input  logic                           retire_valid,
  input  logic [XLEN-1:0]                retire_pc,
  input  logic                           retire_we,
  input  logic [4:0]                     retire_rd,
  input  logic [XLEN-1:0]                retire_data,
  output logic [CNT_W-1:0]               cycle_cnt,
  output logic [CNT_W-1:0]               instret_cnt,
  output logic [CNT_W-1:0]               stall_cnt,
  output logic [CNT_W-1:0]               flush_cnt,
  output logic [CNT_W-1:0]               branch_cnt,
  output logic                           trace_valid,
  input  logic                           trace_ready,
  output logic [XLEN-1:0]                trace_pc,
  output logic [4:0]                     trace_rd,
  output logic [XLEN-1:0]                trace_data,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count,
  output logic                           trace_overflow
);

  localparam int PTR_W = $clog2(TRACE_DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic ev);
    if (ev && (v != {CNT_W{1'b1}})) return v + 1'b1;
    return v;
  endfunction

  logic [CNT_W-1:0] cycle_q, cycle_d, instret_q, instret_d, stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d, branch_q, branch_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             push, pop, full, wr_en;

  logic [XLEN-1:0]  pc_mem   [TRACE_DEPTH];
  logic [4:0]       rd_mem   [TRACE_DEPTH];
  logic [XLEN-1:0]  data_mem [TRACE_DEPTH];

  assign trace_valid = (count_q != '0);
  // Depth is a power of two, so the occupancy MSB alone marks full.
  assign full        = count_q[PTR_W];
  assign push        = enable && retire_valid;
  assign pop         = trace_valid && trace_ready;

  always_comb begin
    cycle_d   = cycle_q;
    instret_d = instret_q;
    stall_d   = stall_q;
    flush_d   = flush_q;
    branch_d  = branch_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    wr_en     = 1'b0;

    if (enable) begin
      cycle_d   = sat_inc(cycle_q, 1'b1);
      instret_d = sat_inc(instret_q, retire_valid);
      stall_d   = sat_inc(stall_q, stall_if || stall_id);
      flush_d   = sat_inc(flush_q, flush_ex);
      branch_d  = sat_inc(branch_q, branch_taken);
    end

    if (push && (!full || pop || (TRACE_MODE == 1))) begin
      wr_en  = 1'b1;
      tail_d = tail_q + 1'b1;
    end
    // Overwrite mode retires the oldest entry to make room for the newest.
    if (pop || (push && full && (TRACE_MODE == 1))) head_d = head_q + 1'b1;
    if (push && full && !pop) ovf_d = 1'b1;

    if (push && !full && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push)          count_d = count_q - 1'b1;

    if (clear) begin
      cycle_d   = '0;
      instret_d = '0;
      stall_d   = '0;
      flush_d   = '0;
      branch_d  = '0;
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      ovf_d     = 1'b0;
      wr_en     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
      branch_q  <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
      branch_q  <= branch_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // Trace storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      pc_mem[tail_q]   <= retire_pc;
      rd_mem[tail_q]   <= retire_we ? retire_rd : 5'd0;
      data_mem[tail_q] <= retire_we ? retire_data : '0;
    end
  end

  assign trace_pc       = trace_valid ? pc_mem[head_q]   : '0;
  assign trace_rd       = trace_valid ? rd_mem[head_q]   : 5'd0;
  assign trace_data     = trace_valid ? data_mem[head_q] : '0;
  assign trace_count    = count_q;
  assign trace_overflow = ovf_q;
  assign cycle_cnt      = cycle_q;
  assign instret_cnt    = instret_q;
  assign stall_cnt      = stall_q;
  assign flush_cnt      = flush_q;
  assign branch_cnt     = branch_q;

endmodule
